// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader.
//   - state_t and the IDLE/RUN/DRAIN encodings used by fifo_burst_reader
//   - has_credit(): decides whether another FIFO read may be issued without
//     overflowing the 2-entry output buffer
package fifo_burst_reader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StRun   = 2'd1;
    localparam state_t StDrain = 2'd2;

    // Words already buffered plus the one in flight, minus the word leaving
    // this cycle, must stay below the buffer depth of 2 before issuing.
    function automatic logic has_credit(input logic [1:0] held,
                                        input logic       inflight,
                                        input logic       popped);
        return ({1'b0, held} + {2'b00, inflight}) < (3'd2 + {2'b00, popped});
    endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry in-order stream buffer (head/tail shift register).
// Ports:
//   clk, n_reset    clock, synchronous active-low reset (clears entries)
//   push, push_data write one entry (ignored when full and not popping)
//   pop             remove the head entry (ignored when empty)
//   head            current head entry
//   valid           buffer non-empty
//   count           number of entries held (0..2)
module stream_buf2 #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop_ok, push_ok;

    assign pop_ok  = pop & (cnt_q != 2'd0);
    assign push_ok = push & ((cnt_q != 2'd2) | pop_ok);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push_ok, pop_ok})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = push_data;
                else               tail_d = push_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the new word lands behind whatever remains.
                if (cnt_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head  = head_q;
    assign valid = (cnt_q != 2'd0);
    assign count = cnt_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads a burst of len words from a synchronous FIFO (one-cycle read latency)
// and presents them as a valid/ready stream with m_last on the final word.
// Ports:
//   clk, n_reset           clock, synchronous active-low reset
//   fifo_empty/rd_en/data  FIFO read side; data valid the cycle after rd_en
//   start, len             burst request (len sampled with start, ignored when busy)
//   busy, done             burst in progress / one-cycle completion pulse
//   m_data/valid/ready/last output stream
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_data,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);

    localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] issue_cnt_q;   // reads issued to the FIFO
    logic [LEN_WIDTH-1:0] ret_cnt_q;     // words returned from the FIFO
    logic                 inflight_q;    // read issued last cycle, data arrives now
    logic                 done_q;

    logic                 rd_en;
    logic                 pop;
    logic                 last_issue;
    logic                 ret_last;
    logic                 start_idle;
    logic                 buf_valid;
    logic [1:0]           buf_count;
    logic [WIDTH:0]       buf_head;

    assign start_idle = start & (state_q == StIdle);
    assign pop        = buf_valid & m_ready;
    assign last_issue = (issue_cnt_q == len_q - LenOne);
    assign ret_last   = (ret_cnt_q == len_q - LenOne);

    assign rd_en = (state_q == StRun) && (issue_cnt_q != len_q) && !fifo_empty &&
                   has_credit(buf_count, inflight_q, pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start && (len != '0))  state_d = StRun;
            StRun:   if (rd_en && last_issue)   state_d = StDrain;
            StDrain: if (pop && buf_head[WIDTH]) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_en;
            if (start_idle) begin
                len_q       <= len;
                issue_cnt_q <= '0;
                ret_cnt_q   <= '0;
            end else begin
                if (rd_en)      issue_cnt_q <= issue_cnt_q + LenOne;
                if (inflight_q) ret_cnt_q   <= ret_cnt_q + LenOne;
            end
            // Zero-length bursts complete immediately; others on the last transfer.
            done_q <= (start_idle && (len == '0)) ||
                      ((state_q == StDrain) && pop && buf_head[WIDTH]);
        end
    end

    // Entries carry {last, data}; last is tagged as the word returns.
    stream_buf2 #(
        .WIDTH (WIDTH + 1)
    ) u_buf (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (inflight_q),
        .push_data ({ret_last, fifo_data}),
        .pop       (pop),
        .head      (buf_head),
        .valid     (buf_valid),
        .count     (buf_count)
    );

    assign fifo_rd_en = rd_en;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign m_valid    = buf_valid;
    assign m_data     = buf_head[WIDTH-1:0];
    assign m_last     = buf_valid & buf_head[WIDTH];

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic       m_ready = 1'b1;
    logic [7:0] fifo_data = 8'd0;
    wire        fifo_empty;
    wire        fifo_rd_en;
    wire        busy;
    wire        done;
    wire  [7:0] m_data;
    wire        m_valid;
    wire        m_last;

    fifo_burst_reader #(
        .WIDTH     (8),
        .LEN_WIDTH (8)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    // FIFO model: the write log doubles as the expected word stream.
    logic [7:0] fifo_mem [4096];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state (burst-level view).
    logic rst_at_edge = 1'b1;
    always @(posedge clk) rst_at_edge <= !n_reset;

    int  cyc = 0;
    bit  mdl_active = 0;
    bit  mdl_done_next = 0;
    int  mdl_len = 0;
    int  mdl_issued = 0;
    int  mdl_xfer = 0;
    int  stream_pos = 0;
    int  done_count = 0;
    int  done_cyc = 0;
    int  start_cyc = 0;
    int  xfer_log[$];
    bit  prev_valid = 0;
    bit  prev_ready = 0;
    logic [7:0] prev_data = 0;
    bit  prev_last = 0;

    always @(negedge clk) begin
        bit was_active;
        bit xfer;
        cyc++;
        if (rst_at_edge) begin
            check("rst_rd_en", fifo_rd_en, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_m_valid", m_valid, 0);
            check("rst_m_last", m_last, 0);
            check("rst_m_data", m_data, 0);
            mdl_active    = 0;
            mdl_done_next = 0;
            stream_pos    = rd_ptr;
            prev_valid    = 0;
        end else begin
            was_active = mdl_active;
            check("busy", busy, mdl_active);
            check("done", done, mdl_done_next);
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (fifo_empty) check("rd_when_empty", fifo_rd_en, 0);
            if (!was_active) begin
                check("idle_rd_en", fifo_rd_en, 0);
                check("idle_m_valid", m_valid, 0);
            end
            if (prev_valid && !prev_ready) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
                check("stall_last", m_last, prev_last);
            end
            mdl_done_next = 0;
            xfer = m_valid && m_ready;
            if (was_active && fifo_rd_en) mdl_issued++;
            if (was_active && xfer) begin
                check("data", m_data, fifo_mem[stream_pos]);
                stream_pos++;
                mdl_xfer++;
                xfer_log.push_back(cyc);
                check("last", m_last, mdl_xfer == mdl_len);
                if (mdl_xfer == mdl_len) begin
                    check("rd_count", mdl_issued, mdl_len);
                    mdl_active    = 0;
                    mdl_done_next = 1;
                end
            end
            if (was_active && fifo_rd_en) check("credit", (mdl_issued - mdl_xfer) <= 2, 1);
            if (start && !was_active) begin
                start_cyc = cyc;
                if (len == 8'd0) begin
                    mdl_done_next = 1;
                end else begin
                    mdl_active = 1;
                    mdl_len    = len;
                    mdl_issued = 0;
                    mdl_xfer   = 0;
                end
            end
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // m_ready driver: 0 = always ready, 1 = random, 2 = pattern 1,0,0 repeating.
    int rdy_mode = 0;
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       m_ready = ($urandom_range(0, 1) == 1);
                2:       m_ready = ((k % 3) == 0);
                default: m_ready = 1'b1;
            endcase
            k++;
        end
    end

    task automatic push_word(input logic [7:0] v);
        fifo_mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic pulse_start(input int l);
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = l[7:0];
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int seen;
        int n;
        seen = done_count;
        n = 0;
        while (done_count == seen && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(tag, done_count != seen, 1);
    endtask

    initial begin
        int l, pre, rem, n, seen, issued_before;
        for (int i = 0; i < 4096; i++) fifo_mem[i] = 8'h00;
        n_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;

        // Preloaded burst at full rate.
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) push_word(8'h10 + 8'(i));
        xfer_log.delete();
        issued_before = rd_ptr;
        pulse_start(4);
        wait_done("t1_done", 50);
        check("t1_nxfer", xfer_log.size(), 4);
        if (xfer_log.size() == 4) begin
            check("t1_first_lat", xfer_log[0] - start_cyc, 3);
            for (int i = 1; i < 4; i++) check("t1_gap", xfer_log[i] - xfer_log[i-1], 1);
            check("t1_done_lat", done_cyc - xfer_log[3], 1);
        end
        check("t1_rd_pulses", rd_ptr - issued_before, 4);

        // Same burst with back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) push_word(8'h10 + 8'(i));
        pulse_start(4);
        wait_done("t2_done", 100);
        rdy_mode = 0;

        // FIFO starts empty; words trickle in.
        pulse_start(3);
        for (int i = 0; i < 3; i++) begin
            repeat (5) @(posedge clk);
            #1 push_word(8'hA1 + 8'(i));
        end
        wait_done("t3_done", 50);

        // Zero-length burst.
        pulse_start(0);
        wait_done("t4_done", 10);
        check("t4_done_lat", done_cyc - start_cyc, 1);

        // Reset mid-burst, with an ignored start while busy.
        for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i));
        pulse_start(8);
        start = 1'b1;
        len   = 8'd2;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (mdl_xfer < 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("t5_three_xfers", mdl_xfer >= 3, 1);
        seen = done_count;
        #1 n_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        repeat (5) @(posedge clk);
        check("t5_no_done", done_count - seen, 0);

        // Randomized bursts.
        for (int b = 0; b < 14; b++) begin
            l = $urandom_range(0, 9);
            pre = $urandom_range(0, l);
            rdy_mode = $urandom_range(0, 2);
            for (int i = 0; i < pre; i++) push_word(8'($urandom_range(0, 255)));
            rem = l - pre;
            seen = done_count;
            pulse_start(l);
            n = 0;
            while (done_count == seen && n < 500) begin
                @(posedge clk);
                #1 start = 1'b0;
                if (rem > 0 && $urandom_range(0, 2) == 0) begin
                    push_word(8'($urandom_range(0, 255)));
                    rem--;
                end
                if (mdl_active && (mdl_xfer + 1 < mdl_len) && $urandom_range(0, 6) == 0) begin
                    start = 1'b1;
                    len   = 8'($urandom_range(0, 255));
                end
                n++;
            end
            start = 1'b0;
            check("rand_done", done_count != seen, 1);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
